// File: rtl/greycode_pkg.sv
// Shared types and helpers for the grey-code loopback status blocks.
// Provides the lock FSM state type and a lowest-set-bit index helper.
package greycode_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    LOCKING,
    LOCKED
  } lock_state_e;

  // 1-based index of the lowest set bit of v; 0 when v is all zero.
  function automatic int unsigned lowest_set(input logic [31:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = i + 1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/latency_detect_if.sv
// Loopback sample/status bundle between the loop pins and latency_detect.
// master drives i_en/i_out/i_ret; slave returns o_diff/o_lat/o_locked/o_err_cnt.
interface latency_detect_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int ERR_W = 16
);
  localparam int LAT_W = $clog2(DEPTH + 1);

  logic             i_en;
  logic [WIDTH-1:0] i_out;
  logic [WIDTH-1:0] i_ret;
  logic [DEPTH-1:0] o_diff;
  logic [LAT_W-1:0] o_lat;
  logic             o_locked;
  logic [ERR_W-1:0] o_err_cnt;

  modport master (
    output i_en, i_out, i_ret,
    input  o_diff, o_lat, o_locked, o_err_cnt
  );

  modport slave (
    input  i_en, i_out, i_ret,
    output o_diff, o_lat, o_locked, o_err_cnt
  );
endinterface

// File: rtl/latency_detect_taps.sv
// tap_delay_line: enabled shift register of transmitted words.
// Ports: i_clk/i_rst/i_en, i_d in; o_taps (tap k at [k-1]), o_valid out.
module tap_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_en,
  input  logic [WIDTH-1:0]            i_d,
  output logic [DEPTH-1:0][WIDTH-1:0] o_taps,
  output logic [DEPTH-1:0]            o_valid
);
  localparam int FILL_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] taps_q;
  logic [FILL_W-1:0]           fill_q;

  // Data taps carry no reset; fill_q masks stale contents.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      taps_q[0] <= i_d;
      for (int k = 1; k < DEPTH; k++) begin
        taps_q[k] <= taps_q[k-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fill_q <= '0;
    end else if (i_en && fill_q != FILL_W'(DEPTH)) begin
      fill_q <= fill_q + FILL_W'(1);
    end
  end

  always_comb begin
    o_valid = '0;
    for (int k = 0; k < DEPTH; k++) begin
      o_valid[k] = fill_q > FILL_W'(k);
    end
  end

  assign o_taps = taps_q;

endmodule

// File: rtl/latency_detect.sv
// Loop-latency detector: finds the lowest delay tap matching the returned
// word, then locks on it. Ports: i_clk, i_rst, bus (latency_detect_if.slave).
module latency_detect
  import greycode_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int LOCK_CNT = 4,
  parameter int MISS_MAX = 2,
  parameter int ERR_W    = 16
) (
  input logic             i_clk,
  input logic             i_rst,
  latency_detect_if.slave bus
);
  localparam int LAT_W = $clog2(DEPTH + 1);
  localparam int CNT_W = $clog2(LOCK_CNT + 1);
  localparam int MIS_W = $clog2(MISS_MAX + 1);

  logic [DEPTH-1:0][WIDTH-1:0] taps;
  logic [DEPTH-1:0]            valid;
  logic [DEPTH-1:0]            hit;
  logic [DEPTH-1:0]            diff_d;
  logic [LAT_W-1:0]            lat_d;
  logic [WIDTH-1:0]            ret_q;

  logic [DEPTH-1:0] diff_q;
  logic [LAT_W-1:0] lat_q;
  logic [DEPTH-1:0] hit_q;

  lock_state_e      state_q;
  logic [DEPTH-1:0] cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic [MIS_W-1:0] miss_q;
  logic             locked_q;
  logic [ERR_W-1:0] err_q;

  tap_delay_line #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_taps (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (bus.i_en),
    .i_d    (bus.i_out),
    .o_taps (taps),
    .o_valid(valid)
  );

  always_ff @(posedge i_clk) begin
    if (bus.i_en) ret_q <= bus.i_ret;
  end

  always_comb begin
    hit = '0;
    for (int k = 0; k < DEPTH; k++) begin
      hit[k] = valid[k] && (taps[k] == ret_q);
    end
  end

  // Isolate lowest set bit for the one-hot view.
  assign diff_d = hit & (~hit + DEPTH'(1));
  assign lat_d  = LAT_W'(lowest_set(32'(hit)));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      diff_q <= '0;
      lat_q  <= '0;
      hit_q  <= '0;
    end else if (bus.i_en) begin
      diff_q <= diff_d;
      lat_q  <= lat_d;
      hit_q  <= hit;
    end
  end

  // Candidate held one-hot; lock is judged on the raw hit of that tap
  // so a lower coincidental match does not count as a miss.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= SEARCH;
      cand_q   <= '0;
      cnt_q    <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= '0;
    end else if (bus.i_en) begin
      unique case (state_q)
        SEARCH: begin
          if (diff_q != '0) begin
            cand_q <= diff_q;
            cnt_q  <= CNT_W'(1);
            if (LOCK_CNT == 1) begin
              state_q  <= LOCKED;
              miss_q   <= '0;
              locked_q <= 1'b1;
            end else begin
              state_q <= LOCKING;
            end
          end
        end
        LOCKING: begin
          if (diff_q == '0) begin
            state_q <= SEARCH;
            cnt_q   <= '0;
          end else if (diff_q == cand_q) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q + CNT_W'(1) == CNT_W'(LOCK_CNT)) begin
              state_q  <= LOCKED;
              miss_q   <= '0;
              locked_q <= 1'b1;
            end
          end else begin
            cand_q <= diff_q;
            cnt_q  <= CNT_W'(1);
          end
        end
        LOCKED: begin
          if (|(hit_q & cand_q)) begin
            miss_q <= '0;
          end else begin
            if (err_q != '1) err_q <= err_q + ERR_W'(1);
            if (miss_q + MIS_W'(1) == MIS_W'(MISS_MAX)) begin
              state_q  <= SEARCH;
              cnt_q    <= '0;
              miss_q   <= '0;
              locked_q <= 1'b0;
            end else begin
              miss_q <= miss_q + MIS_W'(1);
            end
          end
        end
        default: begin
          state_q  <= SEARCH;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_diff    = diff_q;
  assign bus.o_lat     = lat_q;
  assign bus.o_locked  = locked_q;
  assign bus.o_err_cnt = err_q;

endmodule

// File: tb/tb_latency_detect.sv
// Bench for latency_detect: directed loop scenarios plus random traffic,
// checked against a queue-based latency/lock model on two ERR_W builds.
module tb_latency_detect;
  localparam int DEPTH    = 4;
  localparam int LOCK_CNT = 4;
  localparam int MISS_MAX = 2;

  logic clk = 1'b0;
  logic t_rst = 1'b1;
  logic t_en = 1'b0;
  logic [7:0] t_out = '0;
  logic [7:0] t_ret = '0;

  latency_detect_if #(.WIDTH(8), .DEPTH(4), .ERR_W(16)) if_a ();
  latency_detect_if #(.WIDTH(8), .DEPTH(4), .ERR_W(4))  if_b ();

  assign if_a.i_en  = t_en;
  assign if_a.i_out = t_out;
  assign if_a.i_ret = t_ret;
  assign if_b.i_en  = t_en;
  assign if_b.i_out = t_out;
  assign if_b.i_ret = t_ret;

  latency_detect #(
    .WIDTH(8), .DEPTH(4), .LOCK_CNT(4), .MISS_MAX(2), .ERR_W(16)
  ) u_dut_a (
    .i_clk(clk),
    .i_rst(t_rst),
    .bus  (if_a)
  );

  latency_detect #(
    .WIDTH(8), .DEPTH(4), .LOCK_CNT(4), .MISS_MAX(2), .ERR_W(4)
  ) u_dut_b (
    .i_clk(clk),
    .i_rst(t_rst),
    .bus  (if_b)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: taps are "the last k enabled words"; lock follows runs of
  // equal reported latencies.
  int       m_q[$];
  int       m_ret = 0;
  int       m_lat = 0;
  bit [3:0] m_hit = '0;
  bit       m_locked = 0;
  int       m_err = 0;
  int       m_cand = 0;
  int       m_run = 0;
  int       m_miss = 0;

  function automatic void m_step(bit rst, bit e, int o, int r);
    bit [3:0] h;
    int lo;
    if (rst) begin
      m_q.delete();
      m_lat = 0; m_hit = '0; m_locked = 0; m_err = 0;
      m_cand = 0; m_run = 0; m_miss = 0;
      return;
    end
    if (!e) return;
    if (m_locked) begin
      if (m_hit[m_cand-1]) m_miss = 0;
      else begin
        m_miss++;
        m_err++;
        if (m_miss == MISS_MAX) begin
          m_locked = 0;
          m_run = 0;
        end
      end
    end else if (m_lat == 0) begin
      m_run = 0;
    end else begin
      if (m_run != 0 && m_lat == m_cand) m_run++;
      else begin
        m_cand = m_lat;
        m_run = 1;
      end
      if (m_run >= LOCK_CNT) begin
        m_locked = 1;
        m_miss = 0;
      end
    end
    h = '0;
    lo = 0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (m_q.size() >= k && m_q[k-1] == m_ret) begin
        h[k-1] = 1'b1;
        if (lo == 0) lo = k;
      end
    end
    m_hit = h;
    m_lat = lo;
    m_q.push_front(o);
    if (m_q.size() > DEPTH) void'(m_q.pop_back());
    m_ret = r;
  endfunction

  task automatic cmp_all();
    int ed;
    ed = (m_lat == 0) ? 0 : (1 << (m_lat - 1));
    check("diff",    32'(if_a.o_diff),    32'(ed));
    check("lat",     32'(if_a.o_lat),     32'(m_lat));
    check("locked",  32'(if_a.o_locked),  32'(m_locked));
    check("err",     32'(if_a.o_err_cnt), 32'((m_err > 65535) ? 65535 : m_err));
    check("locked4", 32'(if_b.o_locked),  32'(m_locked));
    check("err4",    32'(if_b.o_err_cnt), 32'((m_err > 15) ? 15 : m_err));
  endtask

  logic [7:0] sent[$];
  logic [7:0] ctr  = 8'd0;
  bit         hold = 0;

  // d >= 0: return word is the word sent d enabled cycles ago; d < 0: corrupt.
  task automatic go(input bit rst, input bit e, input int d);
    logic [7:0] o, r;
    if (e) begin
      o = hold ? 8'h55 : ctr;
      if (!hold) ctr = ctr + 8'd1;
      sent.push_back(o);
      if (sent.size() > 8) void'(sent.pop_front());
      if (d < 0) r = o + 8'd100;
      else if (sent.size() > d) r = sent[sent.size()-1-d];
      else r = 8'($urandom);
    end else begin
      o = 8'($urandom);
      r = 8'($urandom);
    end
    t_rst = rst;
    t_en  = e;
    t_out = o;
    t_ret = r;
    m_step(rst, e, int'(o), int'(r));
    @(negedge clk);
    cmp_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int d;
    bit r, e;
    @(negedge clk);
    go(1, 1, 0);
    check("rst_diff",   32'(if_a.o_diff),    32'h0);
    check("rst_locked", 32'(if_a.o_locked),  32'h0);
    check("rst_err",    32'(if_a.o_err_cnt), 32'h0);

    // Delay 1 after a reset with stale 0x55 in the taps.
    hold = 1;
    repeat (5) go(0, 1, 0);
    go(1, 1, 0);
    hold = 0;
    ctr = 8'd0;
    go(0, 1, 1);
    go(0, 1, 1);
    check("t1_mask", 32'(if_a.o_diff), 32'h0);
    go(0, 1, 1);
    check("t1_diff", 32'(if_a.o_diff), 32'h2);
    check("t1_lat",  32'(if_a.o_lat),  32'd2);
    repeat (3) go(0, 1, 1);
    check("t1_prelock", 32'(if_a.o_locked), 32'h0);
    go(0, 1, 1);
    check("t1_lock", 32'(if_a.o_locked),  32'h1);
    check("t1_err",  32'(if_a.o_err_cnt), 32'h0);

    // Direct loop; stale matching taps must stay masked.
    hold = 1;
    repeat (4) go(0, 1, 0);
    go(1, 1, 0);
    go(0, 1, 0);
    check("t2_mask", 32'(if_a.o_diff), 32'h0);
    hold = 0;
    go(0, 1, 0);
    check("t2_diff", 32'(if_a.o_diff), 32'h1);
    repeat (3) go(0, 1, 0);
    check("t2_diff_hold", 32'(if_a.o_diff), 32'h1);

    // Locked at tap 3, single then double corruption.
    go(1, 1, 2);
    repeat (10) go(0, 1, 2);
    check("t3_lock", 32'(if_a.o_locked), 32'h1);
    check("t3_lat",  32'(if_a.o_lat),    32'd3);
    go(0, 1, -1);
    repeat (5) go(0, 1, 2);
    check("t3_err1",  32'(if_a.o_err_cnt), 32'd1);
    check("t3_keep",  32'(if_a.o_locked),  32'h1);
    go(0, 1, -1);
    go(0, 1, -1);
    go(0, 1, 2);
    go(0, 1, 2);
    check("t3_lost", 32'(if_a.o_locked),  32'h0);
    check("t3_err3", 32'(if_a.o_err_cnt), 32'd3);
    repeat (6) go(0, 1, 2);
    check("t3_relock", 32'(if_a.o_locked), 32'h1);

    // Locked at tap 2, loop delay moves to tap 4.
    go(1, 1, 1);
    repeat (10) go(0, 1, 1);
    check("t4_lock", 32'(if_a.o_lat), 32'd2);
    repeat (12) go(0, 1, 3);
    check("t4_lat",    32'(if_a.o_lat),     32'd4);
    check("t4_diff",   32'(if_a.o_diff),    32'h8);
    check("t4_relock", 32'(if_a.o_locked),  32'h1);
    check("t4_err",    32'(if_a.o_err_cnt), 32'd2);

    // Enable low freezes everything, lock survives resume, reset clears.
    for (int i = 0; i < 10; i++) begin
      go(0, 0, 3);
      check("t5_frz_lock", 32'(if_a.o_locked),  32'h1);
      check("t5_frz_lat",  32'(if_a.o_lat),     32'd4);
      check("t5_frz_err",  32'(if_a.o_err_cnt), 32'd2);
    end
    repeat (5) go(0, 1, 3);
    check("t5_resume", 32'(if_a.o_locked), 32'h1);
    go(1, 1, 3);
    check("t5_rst_diff", 32'(if_a.o_diff),    32'h0);
    check("t5_rst_lat",  32'(if_a.o_lat),     32'h0);
    check("t5_rst_lock", 32'(if_a.o_locked),  32'h0);
    check("t5_rst_err",  32'(if_a.o_err_cnt), 32'h0);

    // 21 isolated misses: narrow counter saturates, wide one counts.
    go(1, 1, 2);
    repeat (10) go(0, 1, 2);
    for (int i = 0; i < 21; i++) begin
      go(0, 1, -1);
      go(0, 1, 2);
    end
    repeat (3) go(0, 1, 2);
    check("t6_sat",  32'(if_b.o_err_cnt), 32'hF);
    check("t6_wide", 32'(if_a.o_err_cnt), 32'd21);
    check("t6_lock", 32'(if_b.o_locked),  32'h1);

    // Random traffic against the model.
    d = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) d = $urandom_range(0, 3);
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 7) != 0);
      go(r, e, ($urandom_range(0, 11) == 0) ? -1 : d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/latency_detect.md
Name: latency_detect

Overview:
- Parametrised loop-latency detector for the grey-code loopback path.
- Delays transmitted words (i_out) through a DEPTH-stage tap line and compares each tap against the registered returned word (i_ret). Reports the lowest matching tap as one-hot and binary.
- Adds what the fixed 4-tap comparator lacks: enable, fill qualification, lock FSM, miss tolerance and a saturating error counter.
- Sits between the grey-code generator/loopback pins and the status/readout mux.

Parameters:
- WIDTH, 8: data word width.
- DEPTH, 4: number of delay taps (max detectable latency), >=1.
- LOCK_CNT, 4: consecutive identical nonzero latencies required to lock, >=1.
- MISS_MAX, 2: consecutive misses on the locked tap before losing lock, >=1.
- ERR_W, 16: error counter width.
- LAT_W, $clog2(DEPTH+1): derived localparam, width of o_lat.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_en  in  1  sample enable; all state holds when low.
- i_out  in  WIDTH  word driven out this cycle.
- i_ret  in  WIDTH  word returning from loop.
- o_diff  out  DEPTH  one-hot lowest matching tap; 0 = no match.
- o_lat  out  LAT_W  binary tap index 1..DEPTH; 0 = no match.
- o_locked  out  1  FSM in LOCKED.
- o_err_cnt  out  ERR_W  saturating count of misses while locked.

Behaviour:
- Datapath, updated only when i_en=1:
  - r_ret <= i_ret; tap[1] <= i_out; tap[k] <= tap[k-1].
  - Taps and r_ret are not reset.
- Fill counter:
  - Reset clears fill to 0; it increments per enabled cycle, saturating at DEPTH.
  - Tap k is valid only when fill >= k. A matching invalid tap is ignored.
- Match vector: hit[k] = valid[k] && (r_ret == tap[k]), combinational.
- Registered on enabled cycles:
  - o_diff = lowest-index set bit of hit.
  - o_lat = that index (1-based); r_hit = hit.
  - Latency: i_ret sampled at edge n, captured in r_ret at edge n, appears on o_diff/o_lat after edge n+1.
- Mapping: i_ret equal to i_out delayed by d cycles (d = 0..DEPTH-1) yields tap d+1.
- FSM (states SEARCH, LOCKING, LOCKED) advances on enabled cycles using registered o_lat/r_hit. It lags o_diff by one cycle.
  - SEARCH: o_lat != 0 -> LOCKING, cand = o_lat, cnt = 1.
  - LOCKING:
    - o_lat == cand -> cnt++; when cnt reaches LOCK_CNT -> LOCKED, miss = 0.
    - o_lat nonzero and != cand -> cand = o_lat, cnt = 1.
    - o_lat == 0 -> SEARCH.
    - LOCK_CNT = 1 locks directly from SEARCH on the first nonzero o_lat.
  - LOCKED:
    - The test is r_hit[cand], not the priority result, so a coincidental lower-tap match does not disturb lock.
    - Hit -> miss = 0.
    - Miss -> miss++ and o_err_cnt++ (saturating at all-ones, never wraps).
    - miss reaching MISS_MAX -> SEARCH, cnt = 0.
- o_locked = (state == LOCKED), registered.
- Reset values: o_diff = 0, o_lat = 0, o_locked = 0, o_err_cnt = 0, state = SEARCH, fill/cnt/miss/cand = 0.
- Reset mid-operation clears lock and error count within one clock. Refill is required before any match is reported.
- o_err_cnt is cleared only by reset, not by losing lock.
- When i_en=0: no shift, no compare update, FSM and counters hold. Outputs keep their last values.

Decomposition:
- Shared package greycode_pkg:
  - State enum type (SEARCH/LOCKING/LOCKED).
  - Function for the lowest-set-bit index, reused by other status blocks.
- Natural sub-module: tap_delay_line (WIDTH, DEPTH). Shift register with enable and fill/valid outputs.
- The comparator/priority logic and FSM stay in latency_detect.

Test Plan:
- Bench setup: DEPTH=4, LOCK_CNT=4, MISS_MAX=2, WIDTH=8. i_out counts 0,1,2,..., i_en=1.
- i_ret = i_out delayed 1 cycle -> o_diff=4'b0010 and o_lat=2 from the first valid cycle; o_locked rises one cycle after the 4th consecutive o_lat=2. o_err_cnt=0.
- i_ret = i_out direct, immediately after reset -> o_diff=4'b0001 after 2 clocks. Taps 2..4 stay masked until fill, with no spurious match on uninitialised taps.
- Locked at tap 3, then corrupt i_ret for 1 cycle -> o_err_cnt=1, o_locked stays 1. Corrupt for 2 consecutive cycles -> o_err_cnt=3 cumulative, o_locked falls, FSM returns to SEARCH, relocks after 4 good matches.
- Locked at tap 2, then switch loop delay to tap 4 -> misses count, lock is lost after 2 misses, candidate becomes 4, relocks with o_lat=4.
- Locked, hold i_en=0 for 10 cycles with random i_ret -> all outputs frozen, o_err_cnt unchanged. Resume -> lock is retained. Assert i_rst for 1 cycle mid-stream -> all outputs 0 next cycle.
- Force 2^ERR_W+5 misses (ERR_W=4 instance) -> o_err_cnt saturates at 4'hF.
